// File: rtl/rv32_alu_issue_wb.sv
// Issue/writeback sequencer around the 16-bit-sliced multicycle ALU: decodes one RV32I ALU op,
// reads the register file, holds operands while the ALU runs, and writes the result back to rd.
module rv32_alu_issue_wb #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr,
  output logic        o_instr_ready,
  output logic        o_rf_ren,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic [31:0] o_alu_operand_one,
  output logic [31:0] o_alu_operand_two,
  output logic [1:0]  o_alu_sel,
  output logic        o_alu_restart,
  output logic        o_alu_hold,
  input  logic        i_alu_data_valid,
  input  logic [31:0] i_alu_result,
  output logic        o_rd_we,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_done,
  output logic        o_illegal,
  output logic        o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q;
  logic [CW-1:0] wait_cnt_q;
  logic [4:0]    rs1_q;
  logic [4:0]    rs2_q;
  logic [4:0]    rd_q;
  logic [11:0]   imm_q;
  logic          is_imm_q;
  logic [1:0]    op_sel_q;
  logic [31:0]   operand_one_q;
  logic [31:0]   operand_two_q;
  logic [1:0]    alu_sel_q;
  logic [31:0]   rd_data_q;
  logic          ready_q;
  logic          rf_ren_q;
  logic          restart_q;
  logic          hold_q;
  logic          rd_we_q;
  logic          done_q;
  logic          illegal_q;
  logic          timeout_q;

  logic          fn_ok_s;
  logic          dec_legal_s;
  logic          dec_imm_s;
  logic [1:0]    dec_sel_s;

  // Decode the offered instruction: funct3 picks the ALU op, opcode/funct7 gate legality.
  always_comb begin
    fn_ok_s     = 1'b0;
    dec_sel_s   = 2'b00;
    dec_imm_s   = 1'b0;
    dec_legal_s = 1'b0;
    case (i_instr[14:12])
      3'b000:  begin fn_ok_s = 1'b1; dec_sel_s = 2'b00; end
      3'b111:  begin fn_ok_s = 1'b1; dec_sel_s = 2'b01; end
      3'b110:  begin fn_ok_s = 1'b1; dec_sel_s = 2'b10; end
      3'b100:  begin fn_ok_s = 1'b1; dec_sel_s = 2'b11; end
      default: begin fn_ok_s = 1'b0; dec_sel_s = 2'b00; end
    endcase
    case (i_instr[6:0])
      7'b0110011: begin
        dec_imm_s   = 1'b0;
        dec_legal_s = fn_ok_s && (i_instr[31:25] == 7'b0000000);
      end
      7'b0010011: begin
        dec_imm_s   = 1'b1;
        dec_legal_s = fn_ok_s;
      end
      default: begin
        dec_imm_s   = 1'b0;
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM; every output is a register updated on the transition into the state that owns it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      rs1_q         <= 5'd0;
      rs2_q         <= 5'd0;
      rd_q          <= 5'd0;
      imm_q         <= 12'd0;
      is_imm_q      <= 1'b0;
      op_sel_q      <= 2'b00;
      operand_one_q <= 32'd0;
      operand_two_q <= 32'd0;
      alu_sel_q     <= 2'b00;
      rd_data_q     <= 32'd0;
      ready_q       <= 1'b1;
      rf_ren_q      <= 1'b0;
      restart_q     <= 1'b0;
      hold_q        <= 1'b1;
      rd_we_q       <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      rf_ren_q  <= 1'b0;
      restart_q <= 1'b0;
      rd_we_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_instr_valid) begin
            if (dec_legal_s) begin
              rs1_q    <= i_instr[19:15];
              rs2_q    <= i_instr[24:20];
              rd_q     <= i_instr[11:7];
              imm_q    <= i_instr[31:20];
              is_imm_q <= dec_imm_s;
              op_sel_q <= dec_sel_s;
              ready_q  <= 1'b0;
              rf_ren_q <= 1'b1;
              state_q  <= S_READ;
            end else begin
              illegal_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_READ: begin
          restart_q <= 1'b1;
          state_q   <= S_ISSUE;
        end
        S_ISSUE: begin
          // Register file data is valid only in this cycle.
          operand_one_q <= i_rs1_data;
          operand_two_q <= is_imm_q ? {{20{imm_q[11]}}, imm_q} : i_rs2_data;
          alu_sel_q     <= op_sel_q;
          wait_cnt_q    <= '0;
          hold_q        <= 1'b0;
          state_q       <= S_WAIT;
        end
        S_WAIT: begin
          if (i_alu_data_valid) begin
            rd_data_q <= i_alu_result;
            rd_we_q   <= (rd_q != 5'd0);
            done_q    <= 1'b1;
            hold_q    <= 1'b1;
            state_q   <= S_WB;
          end else if (wait_cnt_q == WAIT_LAST) begin
            timeout_q <= 1'b1;
            hold_q    <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_WB: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          hold_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_instr_ready     = ready_q;
  assign o_rf_ren          = rf_ren_q;
  assign o_rs1_addr        = rs1_q;
  assign o_rs2_addr        = rs2_q;
  assign o_alu_operand_one = operand_one_q;
  assign o_alu_operand_two = operand_two_q;
  assign o_alu_sel         = alu_sel_q;
  assign o_alu_restart     = restart_q;
  assign o_alu_hold        = hold_q;
  assign o_rd_we           = rd_we_q;
  assign o_rd_addr         = rd_q;
  assign o_rd_data         = rd_data_q;
  assign o_done            = done_q;
  assign o_illegal         = illegal_q;
  assign o_timeout         = timeout_q;

endmodule

// File: tb/tb_rv32_alu_issue_wb.sv
// Randomized bench for rv32_alu_issue_wb: a register-file/ALU environment plus an
// instruction-level reference model that predicts operands, writeback and pulses.
module tb_rv32_alu_issue_wb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_instr_valid;
  logic [31:0] i_instr;
  logic        o_instr_ready;
  logic        o_rf_ren;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [31:0] o_alu_operand_one;
  logic [31:0] o_alu_operand_two;
  logic [1:0]  o_alu_sel;
  logic        o_alu_restart;
  logic        o_alu_hold;
  logic        i_alu_data_valid;
  logic [31:0] i_alu_result;
  logic        o_rd_we;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_done;
  logic        o_illegal;
  logic        o_timeout;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rf [32];

  rv32_alu_issue_wb #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_instr_valid(i_instr_valid), .i_instr(i_instr), .o_instr_ready(o_instr_ready),
    .o_rf_ren(o_rf_ren), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .o_alu_operand_one(o_alu_operand_one), .o_alu_operand_two(o_alu_operand_two),
    .o_alu_sel(o_alu_sel), .o_alu_restart(o_alu_restart), .o_alu_hold(o_alu_hold),
    .i_alu_data_valid(i_alu_data_valid), .i_alu_result(i_alu_result),
    .o_rd_we(o_rd_we), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
    .o_done(o_done), .o_illegal(o_illegal), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  // Environment ALU: computes whatever the DUT presents to it.
  function automatic logic [31:0] alu_env(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] sel);
    case (sel)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Instruction-level expectation straight from the RV32I semantics of the supported ops.
  task automatic ref_model(input logic [31:0] instr, output logic legal, output logic [1:0] sel,
                           output logic [31:0] a, output logic [31:0] b, output logic [31:0] res);
    logic [6:0] op;
    logic [2:0] f3;
    logic       is_r;
    logic       is_i;
    op    = instr[6:0];
    f3    = instr[14:12];
    is_r  = (op == 7'b0110011) && (instr[31:25] == 7'd0);
    is_i  = (op == 7'b0010011);
    legal = (is_r || is_i) && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b100);
    a     = rf[instr[19:15]];
    b     = is_i ? 32'($signed(instr[31:20])) : rf[instr[24:20]];
    sel   = 2'b00;
    res   = 32'd0;
    if (f3 == 3'b000) begin sel = 2'b00; res = a + b; end
    else if (f3 == 3'b111) begin sel = 2'b01; res = a & b; end
    else if (f3 == 3'b110) begin sel = 2'b10; res = a | b; end
    else if (f3 == 3'b100) begin sel = 2'b11; res = a ^ b; end
  endtask

  // delay: WAIT cycle on which the ALU raises valid; 0 = reset during first WAIT; >TMO = withheld.
  task automatic run_instr(input logic [31:0] instr, input int delay);
    logic        legal;
    logic [1:0]  esel;
    logic [31:0] ea, eb, eres;
    logic [4:0]  rd;
    logic        got;
    ref_model(instr, legal, esel, ea, eb, eres);
    rd = instr[11:7];
    check_eq("ready_idle", 32'(o_instr_ready), 32'd1);
    i_instr_valid = 1'b1;
    i_instr       = instr;
    @(negedge clk);
    i_instr_valid = 1'b0;
    i_instr       = $urandom;
    if (!legal) begin
      check_eq("illegal_pulse", 32'(o_illegal), 32'd1);
      check_eq("illegal_no_ren", 32'(o_rf_ren), 32'd0);
      check_eq("illegal_ready", 32'(o_instr_ready), 32'd1);
      return;
    end
    check_eq("legal_no_illegal", 32'(o_illegal), 32'd0);
    check_eq("read_ren", 32'(o_rf_ren), 32'd1);
    check_eq("read_rs1", 32'(o_rs1_addr), 32'(instr[19:15]));
    check_eq("read_rs2", 32'(o_rs2_addr), 32'(instr[24:20]));
    check_eq("read_busy", 32'(o_instr_ready), 32'd0);
    i_rs1_data       = $urandom;
    i_rs2_data       = $urandom;
    i_alu_data_valid = 1'b1;
    i_alu_result     = $urandom;
    @(negedge clk);
    check_eq("issue_restart", 32'(o_alu_restart), 32'd1);
    check_eq("issue_hold", 32'(o_alu_hold), 32'd1);
    i_rs1_data       = rf[instr[19:15]];
    i_rs2_data       = rf[instr[24:20]];
    i_alu_data_valid = 1'b0;
    @(negedge clk);
    i_rs1_data = $urandom;
    i_rs2_data = $urandom;
    check_eq("wait_restart_low", 32'(o_alu_restart), 32'd0);
    check_eq("wait_hold", 32'(o_alu_hold), 32'd0);
    check_eq("operand_a", o_alu_operand_one, ea);
    check_eq("operand_b", o_alu_operand_two, eb);
    check_eq("alu_sel", 32'(o_alu_sel), 32'(esel));
    if (delay == 0) begin
      i_rst            = 1'b1;
      i_alu_data_valid = 1'b1;
      i_alu_result     = $urandom;
      @(negedge clk);
      i_rst            = 1'b0;
      i_alu_data_valid = 1'b0;
      check_eq("rst_ready", 32'(o_instr_ready), 32'd1);
      check_eq("rst_hold", 32'(o_alu_hold), 32'd1);
      check_eq("rst_no_we", 32'(o_rd_we), 32'd0);
      check_eq("rst_no_done", 32'(o_done), 32'd0);
      check_eq("rst_no_timeout", 32'(o_timeout), 32'd0);
      check_eq("rst_operand_a", o_alu_operand_one, 32'd0);
      @(negedge clk);
      check_eq("rst_after_no_we", 32'(o_rd_we), 32'd0);
      check_eq("rst_after_no_done", 32'(o_done), 32'd0);
      return;
    end
    got = 1'b0;
    for (int k = 1; k <= TMO && !got; k++) begin
      i_alu_data_valid = (k == delay);
      i_alu_result     = (k == delay) ? alu_env(o_alu_operand_one, o_alu_operand_two, o_alu_sel)
                                      : $urandom;
      @(negedge clk);
      if (k == delay) got = 1'b1;
    end
    i_alu_data_valid = 1'b0;
    if (got) begin
      check_eq("wb_we", 32'(o_rd_we), 32'(rd != 5'd0));
      check_eq("wb_done", 32'(o_done), 32'd1);
      check_eq("wb_rd", 32'(o_rd_addr), 32'(rd));
      check_eq("wb_data", o_rd_data, eres);
      check_eq("wb_no_timeout", 32'(o_timeout), 32'd0);
      if (rd != 5'd0) rf[rd] = eres;
      @(negedge clk);
      check_eq("post_wb_we", 32'(o_rd_we), 32'd0);
      check_eq("post_wb_done", 32'(o_done), 32'd0);
      check_eq("post_wb_ready", 32'(o_instr_ready), 32'd1);
      check_eq("operand_a_stable", o_alu_operand_one, ea);
    end else begin
      check_eq("tmo_pulse", 32'(o_timeout), 32'd1);
      check_eq("tmo_no_we", 32'(o_rd_we), 32'd0);
      check_eq("tmo_no_done", 32'(o_done), 32'd0);
      check_eq("tmo_ready", 32'(o_instr_ready), 32'd1);
      check_eq("tmo_hold", 32'(o_alu_hold), 32'd1);
      @(negedge clk);
      check_eq("tmo_pulse_end", 32'(o_timeout), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] instr;
    logic [6:0]  op;
    int          r;
    int          dly;
    i_rst            = 1'b1;
    i_instr_valid    = 1'b0;
    i_instr          = 32'd0;
    i_rs1_data       = 32'd0;
    i_rs2_data       = 32'd0;
    i_alu_data_valid = 1'b0;
    i_alu_result     = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    check_eq("reset_ready", 32'(o_instr_ready), 32'd1);
    check_eq("reset_hold", 32'(o_alu_hold), 32'd1);
    check_eq("reset_pulses", 32'({o_rf_ren, o_alu_restart, o_rd_we, o_done, o_illegal, o_timeout}), 32'd0);
    check_eq("reset_sel", 32'(o_alu_sel), 32'd0);
    check_eq("reset_operands", o_alu_operand_one | o_alu_operand_two | o_rd_data, 32'd0);

    rf[1] = 32'h0000FFFF;
    rf[2] = 32'h00000001;
    run_instr(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 2);
    run_instr(enc_i(12'hFFF, 5'd0, 3'b000, 5'd5, 7'b0010011), 2);
    rf[6] = 32'hA5A5A5A5;
    rf[7] = 32'h0F0F0F0F;
    run_instr(enc_r(7'd0, 5'd7, 5'd6, 3'b100, 5'd4), 2);
    run_instr(enc_r(7'd0, 5'd7, 5'd6, 3'b110, 5'd4), 2);
    run_instr(enc_r(7'd0, 5'd7, 5'd6, 3'b111, 5'd4), 2);
    run_instr(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd9), 2);
    run_instr(enc_i(12'h004, 5'd1, 3'b010, 5'd9, 7'b0000011), 2);
    run_instr(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd8), TMO + 1);
    run_instr(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd0), 2);
    run_instr(enc_r(7'd0, 5'd2, 5'd1, 3'b110, 5'd10), TMO);
    run_instr(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd11), 0);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 7'b0110011 : (r < 8) ? 7'b0010011 : (r == 8) ? 7'b0000011 : 7'($urandom);
      instr = {($urandom_range(0, 5) == 0) ? 7'b0100000 : 7'd0, 5'($urandom), 5'($urandom),
               3'($urandom), 5'($urandom), op};
      if (op == 7'b0010011) instr[31:20] = 12'($urandom);
      r = $urandom_range(0, 19);
      dly = (r == 0) ? TMO + 1 : (r == 1) ? TMO : (r == 2) ? 1 :
            (r == 3) ? $urandom_range(1, TMO) : 2;
      run_instr(instr, dly);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
